// File: rtl/disparity_wta.sv
// Pipelined winner-takes-all argmin over the aggregated cost vector, with saturation rejection.
// Define WTA_UNIQUE_EN to also reject winners that fail the min2-vs-min1 uniqueness margin.
module disparity_wta #(
    parameter int DISP_NUM     = 108,
    parameter int COST_WIDTH   = 8,
    parameter int DIM_WIDTH    = 10,
    parameter int DISP_WIDTH   = 7,
    parameter int INVALID_DISP = 127,
    parameter int FRAME_ROWS   = 480,
`ifdef WTA_UNIQUE_EN
    parameter int FRAME_COLS   = 640,
    parameter int UNIQ_RATIO   = 10
`else
    parameter int FRAME_COLS   = 640
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DISP_NUM*COST_WIDTH-1:0] cost_aggr,
    input  logic [DIM_WIDTH-1:0]           row,
    input  logic [DIM_WIDTH-1:0]           col,
    input  logic                           valid_in,
    output logic [DISP_WIDTH-1:0]          disp,
    output logic [COST_WIDTH-1:0]          min_cost,
    output logic [DIM_WIDTH-1:0]           out_row,
    output logic [DIM_WIDTH-1:0]           out_col,
    output logic                           valid,
    output logic                           frame_done
);

    localparam int LEVELS = $clog2(DISP_NUM);

    function automatic int lvlCount(input int lvl);
        int n;
        n = DISP_NUM;
        for (int k = 0; k < lvl; k++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    logic [COST_WIDTH-1:0] w_leafCost [DISP_NUM];

    for (genvar d = 0; d < DISP_NUM; d++) begin : g_leaf
        assign w_leafCost[d] = cost_aggr[COST_WIDTH*d +: COST_WIDTH];
    end

    // An odd leftover node is paired with a virtual all-ones right input; since the left
    // side wins ties, it passes through unchanged (its min2 too, as min(min2, max) = min2).
    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int NP = lvlCount(l - 1);
        localparam int N  = lvlCount(l);

        for (genvar i = 0; i < N; i++) begin : g_node
            logic [COST_WIDTH-1:0] w_lCost;
            logic [COST_WIDTH-1:0] w_rCost;
            logic [DISP_WIDTH-1:0] w_lIdx;
            logic [DISP_WIDTH-1:0] w_rIdx;
            logic [COST_WIDTH-1:0] r_cost;
            logic [DISP_WIDTH-1:0] r_idx;
`ifdef WTA_UNIQUE_EN
            logic [COST_WIDTH-1:0] w_lMin2;
            logic [COST_WIDTH-1:0] w_rMin2;
            logic [COST_WIDTH-1:0] r_min2;
`endif

            if (l == 1) begin : g_src
                assign w_lCost = w_leafCost[2*i];
                assign w_lIdx  = DISP_WIDTH'(2*i);
`ifdef WTA_UNIQUE_EN
                assign w_lMin2 = '1;
`endif
                if (2*i + 1 < NP) begin : g_right
                    assign w_rCost = w_leafCost[2*i+1];
                    assign w_rIdx  = DISP_WIDTH'(2*i + 1);
`ifdef WTA_UNIQUE_EN
                    assign w_rMin2 = '1;
`endif
                end else begin : g_right
                    assign w_rCost = '1;
                    assign w_rIdx  = '0;
`ifdef WTA_UNIQUE_EN
                    assign w_rMin2 = '1;
`endif
                end
            end else begin : g_src
                assign w_lCost = g_lvl[l-1].g_node[2*i].r_cost;
                assign w_lIdx  = g_lvl[l-1].g_node[2*i].r_idx;
`ifdef WTA_UNIQUE_EN
                assign w_lMin2 = g_lvl[l-1].g_node[2*i].r_min2;
`endif
                if (2*i + 1 < NP) begin : g_right
                    assign w_rCost = g_lvl[l-1].g_node[2*i+1].r_cost;
                    assign w_rIdx  = g_lvl[l-1].g_node[2*i+1].r_idx;
`ifdef WTA_UNIQUE_EN
                    assign w_rMin2 = g_lvl[l-1].g_node[2*i+1].r_min2;
`endif
                end else begin : g_right
                    assign w_rCost = '1;
                    assign w_rIdx  = '0;
`ifdef WTA_UNIQUE_EN
                    assign w_rMin2 = '1;
`endif
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cost <= '0;
                    r_idx  <= '0;
`ifdef WTA_UNIQUE_EN
                    r_min2 <= '0;
`endif
                end else if (w_lCost <= w_rCost) begin
                    r_cost <= w_lCost;
                    r_idx  <= w_lIdx;
`ifdef WTA_UNIQUE_EN
                    r_min2 <= (w_lMin2 < w_rCost) ? w_lMin2 : w_rCost;
`endif
                end else begin
                    r_cost <= w_rCost;
                    r_idx  <= w_rIdx;
`ifdef WTA_UNIQUE_EN
                    r_min2 <= (w_rMin2 < w_lCost) ? w_rMin2 : w_lCost;
`endif
                end
            end
        end
    end

    logic [COST_WIDTH-1:0] w_winCost;
    logic [DISP_WIDTH-1:0] w_winIdx;
    logic                  w_reject;

    assign w_winCost = g_lvl[LEVELS].g_node[0].r_cost;
    assign w_winIdx  = g_lvl[LEVELS].g_node[0].r_idx;

`ifdef WTA_UNIQUE_EN
    logic [15:0] w_lhs;
    logic [15:0] w_rhs;

    assign w_lhs    = 16'(100) * 16'(g_lvl[LEVELS].g_node[0].r_min2);
    assign w_rhs    = 16'(100 + UNIQ_RATIO) * 16'(w_winCost);
    assign w_reject = (w_winCost == '1) || !(w_lhs > w_rhs);
`else
    assign w_reject = (w_winCost == '1);
`endif

    logic [DIM_WIDTH-1:0] r_rowPipe [LEVELS];
    logic [DIM_WIDTH-1:0] r_colPipe [LEVELS];
    logic                 r_vldPipe [LEVELS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LEVELS; k++) begin
                r_rowPipe[k] <= '0;
                r_colPipe[k] <= '0;
                r_vldPipe[k] <= 1'b0;
            end
        end else begin
            r_rowPipe[0] <= row;
            r_colPipe[0] <= col;
            r_vldPipe[0] <= valid_in;
            for (int k = 1; k < LEVELS; k++) begin
                r_rowPipe[k] <= r_rowPipe[k-1];
                r_colPipe[k] <= r_colPipe[k-1];
                r_vldPipe[k] <= r_vldPipe[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp       <= '0;
            min_cost   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            disp       <= w_reject ? DISP_WIDTH'(INVALID_DISP) : w_winIdx;
            min_cost   <= w_winCost;
            out_row    <= r_rowPipe[LEVELS-1];
            out_col    <= r_colPipe[LEVELS-1];
            valid      <= r_vldPipe[LEVELS-1];
            frame_done <= r_vldPipe[LEVELS-1]
                          && (r_rowPipe[LEVELS-1] == DIM_WIDTH'(FRAME_ROWS - 1))
                          && (r_colPipe[LEVELS-1] == DIM_WIDTH'(FRAME_COLS - 1));
        end
    end

endmodule

// File: tb/tb_disparity_wta.sv
// Scoreboard bench for disparity_wta: a linear-scan reference model predicts each pixel,
// and a monitor pops and compares every valid output including its arrival cycle.
module tb_disparity_wta;

    typedef struct {
        logic [6:0] disp;
        logic [7:0] cost;
        logic [9:0] row;
        logic [9:0] col;
        logic       fd;
        int         due;
    } expT;

    logic         clk = 1'b0;
    logic         rst;
    logic [863:0] costAggr;
    logic [9:0]   row;
    logic [9:0]   col;
    logic         validIn;
    logic [6:0]   disp;
    logic [7:0]   minCost;
    logic [9:0]   outRow;
    logic [9:0]   outCol;
    logic         valid;
    logic         frameDone;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [863:0] stimVec;
    expT          sb[$];

    disparity_wta dut (
        .clk       (clk),
        .rst       (rst),
        .cost_aggr (costAggr),
        .row       (row),
        .col       (col),
        .valid_in  (validIn),
        .disp      (disp),
        .min_cost  (minCost),
        .out_row   (outRow),
        .out_col   (outCol),
        .valid     (valid),
        .frame_done(frameDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain linear scan, strict < keeps the lowest index on ties.
    function automatic expT model(input logic [863:0] v, input logic [9:0] r,
                                  input logic [9:0] c, input int due);
        expT e;
        int  m1, m2, ix, x;
        m1 = int'(v[7:0]);
        m2 = 255;
        ix = 0;
        for (int d = 1; d < 108; d++) begin
            x = int'(v[8*d +: 8]);
            if (x < m1) begin
                m2 = m1;
                m1 = x;
                ix = d;
            end else if (x < m2) begin
                m2 = x;
            end
        end
        e.disp = 7'(ix);
        if (m1 == 255) e.disp = 7'd127;
`ifdef WTA_UNIQUE_EN
        if (!(100 * m2 > 110 * m1)) e.disp = 7'd127;
`endif
        e.cost = 8'(m1);
        e.row  = r;
        e.col  = c;
        e.fd   = (r == 10'd479) && (c == 10'd639);
        e.due  = due;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic setAll(input int v);
        for (int d = 0; d < 108; d++) stimVec[8*d +: 8] = 8'(v);
    endtask

    task automatic setLane(input int d, input int v);
        stimVec[8*d +: 8] = 8'(v);
    endtask

    task automatic applyStimulus(input int r, input int c);
        @(negedge clk);
        costAggr = stimVec;
        row      = 10'(r);
        col      = 10'(c);
        validIn  = 1'b1;
        sb.push_back(model(stimVec, 10'(r), 10'(c), cyc + 8));
    endtask

    task automatic applyBubble();
        @(negedge clk);
        validIn = 1'b0;
    endtask

    task automatic drain();
        applyBubble();
        for (int k = 0; k < 40 && sb.size() > 0; k++) @(negedge clk);
        checkOutput("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every valid output must match the head of the scoreboard on its due cycle.
    initial begin
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b1) begin
                if (valid) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_valid", {22'd0, outRow}, 32'hffff_ffff);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("disp", 32'(disp), 32'(e.disp));
                        checkOutput("min_cost", 32'(minCost), 32'(e.cost));
                        checkOutput("out_row", 32'(outRow), 32'(e.row));
                        checkOutput("out_col", 32'(outCol), 32'(e.col));
                        checkOutput("frame_done", 32'(frameDone), 32'(e.fd));
                        checkOutput("latency_cycle", 32'(cyc), 32'(e.due));
                    end
                end else if (frameDone !== 1'b0) begin
                    checkOutput("frame_done_idle", 32'(frameDone), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        validIn  = 1'b0;
        row      = '0;
        col      = '0;
        costAggr = '0;
        stimVec  = '0;

        // Reset held with valid_in toggling: every output stays at zero.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            validIn  = ~validIn;
            costAggr = {108{8'(k + 1)}};
            #1;
            checkOutput("reset_disp_cost", {17'd0, disp, minCost}, 32'd0);
            checkOutput("reset_rc_flags", {10'd0, outRow, outCol, valid, frameDone}, 32'd0);
        end
        @(negedge clk);
        rst     = 1'b1;
        validIn = 1'b0;

        $display("[TB] directed pixels");
        setAll(200); setLane(53, 4);
        applyStimulus(7, 9);
        setAll(50); setLane(0, 10); setLane(107, 10);
        applyStimulus(1, 2);
        setAll(50); setLane(107, 10);
        applyStimulus(1, 3);
        setAll(255);
        applyStimulus(2, 4);
        setAll(200); setLane(20, 100); setLane(21, 111);
        applyStimulus(3, 5);
        setAll(200); setLane(20, 100); setLane(21, 110);
        applyStimulus(3, 6);
        setAll(90); setLane(5, 1);
        applyStimulus(480, 639);
        applyStimulus(479, 640);
        applyStimulus(1023, 1023);
        drain();

        $display("[TB] streaming last row with one bubble");
        for (int c = 0; c < 640; c++) begin
            if (c == 300) applyBubble();
            setAll(200); setLane(c % 108, 5);
            applyStimulus(479, c);
        end
        drain();

        $display("[TB] mid-stream reset");
        for (int k = 0; k < 4; k++) begin
            setAll(100); setLane(k + 10, 3);
            applyStimulus(479, 636 + k);
        end
        @(negedge clk);
        rst     = 1'b0;
        validIn = 1'b0;
        sb.delete();
        #1;
        checkOutput("midreset_rc_flags", {10'd0, outRow, outCol, valid, frameDone}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);

        setAll(60); setLane(99, 7);
        applyStimulus(479, 639);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disparity_wta.md
Name: disparity_wta

Overview:
- Consumer (reader) of the aggregated-cost stream. Takes one 864-bit vector per pixel (108 disparities x 8 bits), with row/col/valid, as produced by the cost-aggregation stage.
- Runs a pipelined winner-takes-all argmin and emits one disparity per pixel, tagged with the same row/col.
- Sits between cost aggregation and the disparity-map writer.
- Also flags the end of each frame.

Parameters:
- DISP_NUM, 108, number of disparity lanes in the input vector.
- COST_WIDTH, 8, bits per cost lane.
- DIM_WIDTH, 10, width of row/col.
- DISP_WIDTH, 7, width of the disparity output.
- INVALID_DISP, 127, code output for rejected pixels.
- FRAME_ROWS, 480, rows per frame.
- FRAME_COLS, 640, columns per frame.
- UNIQ_RATIO, 10, uniqueness margin in percent (used only with WTA_UNIQUE_EN).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cost_aggr  in  864  aggregated costs; lane d = bits [8d+7:8d]
- row  in  10  pixel row of cost_aggr
- col  in  10  pixel column of cost_aggr
- valid_in  in  1  cost_aggr/row/col valid this cycle
- disp  out  7  winning disparity, or INVALID_DISP
- min_cost  out  8  cost of the winning lane
- out_row  out  10  row aligned with disp
- out_col  out  10  column aligned with disp
- valid  out  1  disp/min_cost/out_row/out_col valid
- frame_done  out  1  one-cycle pulse with the last pixel of a frame

Behaviour:
- Reset: one clock, asynchronous active-low. While rst=0, all pipeline registers and outputs are 0: disp=0, min_cost=0, out_row=0, out_col=0, valid=0, frame_done=0.
- Reset mid-operation: every in-flight pixel is discarded; no partial output appears after release.
- Handshake: valid-only stream, no backpressure.
  - A pixel is accepted on every cycle with valid_in=1. Back-to-back input at 1 pixel/clock is sustained indefinitely.
  - Bubbles (valid_in=0) propagate as valid=0. Data registers may hold stale values during bubbles.
- Argmin tree: 7 registered levels, reducing 108->54->27->14->7->4->2->1.
  - Each node compares pairs (2k, 2k+1) and carries {cost, index}.
  - An odd leftover element passes through that level registered, unchanged.
  - Tie rule: if left cost <= right cost, the left node (lower disparity index) wins. Equal costs therefore always resolve to the lowest disparity.
- Output stage: one further register applies the validity checks below.
- Latency: exactly 8 cycles from valid_in to valid. row/col/valid travel in a matching 8-deep shift register.
- Saturation check: if the winning cost is 255 (all lanes saturated), disp=INVALID_DISP and min_cost=255. valid is still 1.
- Unsigned compares only. No arithmetic on costs except in the uniqueness check.
- frame_done:
  - Asserted together with the output pixel where out_row=FRAME_ROWS-1 and out_col=FRAME_COLS-1 and valid=1.
  - It is position-based only: no internal pixel counter, and no check that earlier pixels arrived.
  - It is never asserted when valid=0.
- Row/col values of FRAME_ROWS or more, or FRAME_COLS or more, pass through unchanged and cannot trigger frame_done.

Optional Feature:
- Macro: WTA_UNIQUE_EN.
- When defined:
  - Each tree node also carries the second-smallest cost of its subtree. The merge is min2 = smallest of the three values other than the overall min. Pass-through nodes keep their min2; a level-0 leaf has min2 = 255.
  - Accept the winner iff 100*min2 > (100+UNIQ_RATIO)*min1, using 16-bit unsigned products. Otherwise disp=INVALID_DISP.
  - min2 is taken over all lanes, including lanes adjacent to the winner.
  - An exact tie (min2 = min1) is always rejected.
  - Latency is unchanged at 8 cycles.
- When undefined: no min2 logic; only the saturation check applies.

Test Plan:
- Reset: hold rst=0 for 5 cycles with valid_in toggling -> all outputs 0 throughout. First valid appears 8 cycles after the first valid_in following release.
- Single minimum: lane 53 = 4, all other lanes = 200, row=7, col=9 -> 8 cycles later disp=53, min_cost=4, out_row=7, out_col=9, valid=1.
- Tie and edge lanes: lanes 0 and 107 = 10, others 50 -> disp=0. With only lane 107 = 10 -> disp=107 (tests the odd pass-through path).
- Saturation: all lanes 255 -> disp=127, min_cost=255, valid=1.
- Streaming and frame end: 640 consecutive pixels of row 479 (cols 0..639), the winner being lane col%108, with one bubble inserted at col 300 -> outputs in order with exactly one valid=0 gap. frame_done=1 only on col 639.
- WTA_UNIQUE_EN with UNIQ_RATIO=10:
  - min1=100, min2=111 -> disp = winner (11100 > 11000).
  - min1=100, min2=110 -> disp=127.
  - Mid-stream: assert rst=0 for 1 cycle with 4 pixels in flight -> none of those 4 pixels is ever output.
